// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: state encoding,
// count limits and the layout of one display digit code.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } timer_state_t;

   localparam int MAX_MIN = 99;
   localparam int MAX_SEC = 59;

   // Digit code layout: enable, 4-bit BCD value, decimal point
   localparam int DIG_EN      = 5;
   localparam int DIG_VAL_MSB = 4;
   localparam int DIG_VAL_LSB = 1;
   localparam int DIG_DP      = 0;

   // Build an enabled digit code from a BCD value and decimal point
   function automatic logic [5:0] make_digit(input logic [3:0] val, input logic dp);
      logic [5:0] code;
      code = '0;
      code[DIG_EN] = 1'b1;
      code[DIG_VAL_MSB:DIG_VAL_LSB] = val;
      code[DIG_DP] = dp;
      return code;
   endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a level command: pulses for the cycle where the
// input is high and its registered previous value is low.
module edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev;

   // Remember last cycle's level; cleared by reset so a level held across
   // reset release still yields exactly one pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/countdown_ctrl.sv
// Minutes/seconds countdown timer with start/pause/stop commands and an
// eight-digit display code output (MM.SS on d4..d1, state code on d5).
module countdown_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_COUNT = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic [6:0] min,
   input  logic [6:0] sec,
   output logic       done,
   output logic       running,
   output logic [5:0] d1,
   output logic [5:0] d2,
   output logic [5:0] d3,
   output logic [5:0] d4,
   output logic [5:0] d5,
   output logic [5:0] d6,
   output logic [5:0] d7,
   output logic [5:0] d8
);

   localparam logic [31:0] TICK_LAST = 32'(TICK_COUNT - 1);

   timer_state_t state, state_next;
   logic [6:0]   min_left, min_next;
   logic [6:0]   sec_left, sec_next;
   logic [31:0]  prescaler, prescaler_next;
   logic         start_edge, pause_edge, stop_edge;
   logic [6:0]   min_sat, sec_sat;
   logic         tick;

   edge_detector u_start_edge (.clock(clock), .reset(reset), .level(start), .pulse(start_edge));
   edge_detector u_pause_edge (.clock(clock), .reset(reset), .level(pause), .pulse(pause_edge));
   edge_detector u_stop_edge  (.clock(clock), .reset(reset), .level(stop),  .pulse(stop_edge));

   // Binary 0..99 to two BCD digits {tens, units}
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'(v / 7'd10);
      units = 4'(v % 7'd10);
      return {tens, units};
   endfunction

   assign min_sat = (min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : min;
   assign sec_sat = (sec > 7'(MAX_SEC)) ? 7'(MAX_SEC) : sec;
   assign tick    = (state == RUN) && (prescaler == TICK_LAST);

   // State, counts and prescaler register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         min_left  <= '0;
         sec_left  <= '0;
         prescaler <= '0;
      end else begin
         state     <= state_next;
         min_left  <= min_next;
         sec_left  <= sec_next;
         prescaler <= prescaler_next;
      end
   end

   // Next-state, count update and command handling (stop > pause > start)
   always_comb begin
      state_next     = state;
      min_next       = min_left;
      sec_next       = sec_left;
      prescaler_next = prescaler;
      case (state)
         IDLE: begin
            min_next = min_sat;
            sec_next = sec_sat;
            if (start_edge) begin
               if ((min_sat != '0) || (sec_sat != '0)) begin
                  state_next     = RUN;
                  prescaler_next = '0;
               end else begin
                  state_next = DONE;
               end
            end
         end
         RUN: begin
            prescaler_next = tick ? 32'd0 : prescaler + 32'd1;
            if (tick) begin
               if (sec_left != '0) begin
                  sec_next = sec_left - 7'd1;
               end else if (min_left != '0) begin
                  min_next = min_left - 7'd1;
                  sec_next = 7'(MAX_SEC);
               end
            end
            // Reaching 00:00 wins over a simultaneous pause so the timer
            // cannot park in PAUSE with nothing left to count
            if (stop_edge)
               state_next = IDLE;
            else if (tick && (min_next == '0) && (sec_next == '0))
               state_next = DONE;
            else if (pause_edge)
               state_next = PAUSE;
         end
         PAUSE: begin
            if (stop_edge)
               state_next = IDLE;
            else if (pause_edge || start_edge)
               state_next = RUN;
         end
         DONE: begin
            min_next = '0;
            sec_next = '0;
            if (stop_edge || start_edge)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign done    = (state == DONE);
   assign running = (state == RUN);

   logic [7:0] min_bcd, sec_bcd;
   assign min_bcd = to_bcd(min_left);
   assign sec_bcd = to_bcd(sec_left);

   assign d4 = make_digit(min_bcd[7:4], 1'b0);
   assign d3 = make_digit(min_bcd[3:0], 1'b1);
   assign d2 = make_digit(sec_bcd[7:4], 1'b0);
   assign d1 = make_digit(sec_bcd[3:0], 1'b0);
   assign d5 = make_digit({2'b00, state}, 1'b0);
   assign d6 = '0;
   assign d7 = '0;
   assign d8 = '0;

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have port clock  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports start, pause, stop  input  1 each  level commands synchronous to clock, acted on at rising edge only.
REQ-005 SHALL have ports min, sec  input  7 each  binary preset minutes and seconds.
REQ-006 SHALL have port done  output  1  high while in DONE.
REQ-007 SHALL have port running  output  1  high while in RUN.
REQ-008 SHALL have ports d1..d8  output  6 each  display digit codes: bit5 enable, bits4:1 BCD value, bit0 decimal point.

Function
REQ-009 SHALL detect a command edge on the cycle where the input is 1 and its registered previous value is 0; previous-value registers are internal.
REQ-010 SHALL implement states IDLE=0, RUN=1, PAUSE=2, DONE=3 in a 2-bit state register; unused encodings none.
REQ-011 SHALL apply command priority stop > pause > start when edges coincide.
REQ-012 IDLE: SHALL load min_left = min saturated to 99 and sec_left = sec saturated to 59 every cycle; stop and pause ignored.
REQ-013 IDLE + start edge: SHALL enter RUN and clear the prescaler if the loaded value is nonzero, else enter DONE.
REQ-014 RUN: prescaler SHALL count 0..TICK_COUNT-1 and wrap; the wrap cycle is a tick.
REQ-015 On tick: sec_left>0 -> sec_left-1; sec_left=0 and min_left>0 -> min_left-1, sec_left=59.
REQ-016 When a tick produces 00:00 the state SHALL be DONE on the following cycle.
REQ-017 RUN + pause edge -> PAUSE; a tick in the same cycle SHALL still decrement.
REQ-018 PAUSE: prescaler and counts SHALL hold; pause or start edge -> RUN with prescaler resumed from held value.
REQ-019 RUN, PAUSE or DONE + stop edge -> IDLE; DONE + start edge -> IDLE.
REQ-020 DONE: SHALL hold 00:00; done=1, running=0.
REQ-021 done and running SHALL be decoded from the state register, valid the same cycle the state changes.
REQ-022 d4/d3 SHALL show min_left tens/units, d2/d1 sec_left tens/units, all enabled; d3 decimal point =1, others 0.
REQ-023 d5 SHALL be enabled showing the state code; d6..d8 SHALL be 6'b000000.
REQ-024 Digit outputs SHALL be combinational from registered counts, zero added latency.

Reset
REQ-025 Reset SHALL force state IDLE, min_left=0, sec_left=0, prescaler=0, edge registers=0, done=0, running=0.
REQ-026 A command held high across reset release SHALL produce one edge on the first clock after release.
REQ-027 Reset mid-RUN SHALL abort immediately; IDLE reload occurs on the first clock after release.

Structure
REQ-028 Package timer_pkg SHALL hold the state enumeration, MAX_MIN=99, MAX_SEC=59, and digit-field bit positions.
REQ-029 The existing edge_detector SHALL be instantiated three times (start, pause, stop); no other sub-module.
REQ-030 Binary-to-BCD for 0..99 SHALL be a local function; prescaler 32 bits.

Verification (TICK_COUNT=4)
REQ-031 min=0, sec=3, start pulse -> running=1; done=1 and d4..d1=0,0,0,0 after 12 clocks plus one.
REQ-032 min=1, sec=0, start -> after first tick d4..d1=0,0,5,9.
REQ-033 IDLE with min=120, sec=75 -> d4..d1=9,9,5,9.
REQ-034 Pause 2 clocks after a tick, hold 20 clocks, pause again -> no decrement while paused; next tick 2 clocks after resume.
REQ-035 stop and pause edges same cycle in RUN -> IDLE; start with min=0, sec=0 -> DONE directly.
REQ-036 Reset asserted mid-RUN -> IDLE, counts 0, done=0; reload matches inputs one clock after release.
